// File: rtl/zap_mem_bus_pkg.sv
// zap_mem_bus_pkg: shared FSM encoding, access-size codes and default timeout for the memory bus arbiter.
package zap_mem_bus_pkg;
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_INSTR, S_RESP} state_t;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam int DEFAULT_TIMEOUT = 255;
endpackage

// File: rtl/zap_mem_sel_gen.sv
// zap_mem_sel_gen: byte-lane select and lane-replicated store data from access size and address; size 3 acts as word.
module zap_mem_sel_gen
  import zap_mem_bus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata_rep
);
  always_comb begin
    sel = size == SZ_BYTE ? 4'b0001 << addr_lo :
          size == SZ_HALF ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'hF;
    wdata_rep = size == SZ_BYTE ? {4{wdata[7:0]}} :
                size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
  end
endmodule

// File: rtl/zap_mem_bus_arbiter.sv
// zap_mem_bus_arbiter: shares one memory bus between fetch and data requesters with alternating fairness.
// Optional access timeout is enabled by defining ZAP_BUS_TIMEOUT_EN.
module zap_mem_bus_arbiter
  import zap_mem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_clear_from_writeback,
  input  logic        i_instr_req,
  input  logic [31:0] i_instr_addr,
  input  logic        i_data_req,
  input  logic        i_data_we,
  input  logic [31:0] i_data_addr,
  input  logic [1:0]  i_data_size,
  input  logic [31:0] i_data_wdata,
  output logic        o_instr_stall,
  output logic        o_instr_done,
  output logic [31:0] o_instr_rdata,
  output logic        o_instr_abort,
  output logic        o_data_stall,
  output logic        o_data_done,
  output logic [31:0] o_data_rdata,
  output logic        o_data_fault,
  output logic        o_bus_stb,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_sel,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic        i_bus_err,
  input  logic [31:0] i_bus_rdata
);
  state_t state, state_d;
  logic last_data, kill, instr_done_q, instr_abort_q;
  logic grant_data, timeout, bus_end, busy;
  logic [3:0] sel_g;
  logic [31:0] wdata_g;
  logic unused_bits;
  assign unused_bits = ^i_instr_addr[1:0];
  zap_mem_sel_gen u_sel (
    .size(i_data_size),
    .addr_lo(i_data_addr[1:0]),
    .wdata(i_data_wdata),
    .sel(sel_g),
    .wdata_rep(wdata_g)
  );
  assign busy = state == S_DATA || state == S_INSTR;
`ifdef ZAP_BUS_TIMEOUT_EN
  logic [31:0] cnt;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) cnt <= '0;
    else cnt <= busy ? cnt + 32'd1 : '0;
  assign timeout = busy && cnt == 32'(TIMEOUT_CYCLES - 1);
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif
  assign bus_end = i_bus_ack | i_bus_err | timeout;
  // Both requesting: data wins unless it had the previous grant.
  assign grant_data = i_data_req & (~i_instr_req | ~last_data);
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:          state_d = grant_data ? S_DATA : i_instr_req ? S_INSTR : S_IDLE;
      S_DATA, S_INSTR: state_d = bus_end ? S_RESP : state;
      default:         state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= S_IDLE;
      last_data <= 1'b0;
      kill <= 1'b0;
      instr_done_q <= 1'b0;
      instr_abort_q <= 1'b0;
      o_instr_rdata <= '0;
      o_data_done <= 1'b0;
      o_data_rdata <= '0;
      o_data_fault <= 1'b0;
      o_bus_stb <= 1'b0;
      o_bus_we <= 1'b0;
      o_bus_addr <= '0;
      o_bus_sel <= '0;
      o_bus_wdata <= '0;
    end else begin
      state <= state_d;
      instr_done_q <= 1'b0;
      instr_abort_q <= 1'b0;
      o_data_done <= 1'b0;
      o_data_fault <= 1'b0;
      if (state == S_IDLE && (i_data_req || i_instr_req)) begin
        o_bus_stb <= 1'b1;
        o_bus_we <= grant_data & i_data_we;
        o_bus_addr <= grant_data ? {i_data_addr[31:2], 2'b00} : {i_instr_addr[31:2], 2'b00};
        o_bus_sel <= grant_data ? sel_g : 4'hF;
        o_bus_wdata <= grant_data ? wdata_g : '0;
        last_data <= grant_data;
        kill <= 1'b0;
      end
      if (state == S_INSTR) kill <= kill | i_clear_from_writeback;
      if (busy && bus_end) begin
        o_bus_stb <= 1'b0;
        if (state == S_DATA) begin
          o_data_done <= 1'b1;
          o_data_rdata <= i_bus_rdata;
          o_data_fault <= i_bus_err | timeout;
        end else begin
          instr_done_q <= 1'b1;
          o_instr_rdata <= i_bus_rdata;
          instr_abort_q <= i_bus_err | timeout;
        end
      end
    end
  end
  // A flush in the response cycle still has to hide the pulse already registered.
  assign o_instr_done = instr_done_q & ~kill & ~i_clear_from_writeback;
  assign o_instr_abort = instr_abort_q & ~kill & ~i_clear_from_writeback;
  assign o_instr_stall = i_instr_req & ~o_instr_done;
  assign o_data_stall = i_data_req & ~o_data_done;
endmodule

// File: doc/zap_mem_bus_arbiter.md
# zap_mem_bus_arbiter

Shares the single external memory bus between the instruction-fetch requester and the data requester that feeds the memory stage. Runs a grant FSM, generates byte selects and lane-replicated store data, and returns raw 32-bit read data; the memory stage performs rotation and extension. Drives the stall signals that freeze fetch and the memory stage while an access is outstanding.

## Interface
- `TIMEOUT_CYCLES`, default 255: bus cycles without ack/err before forced error; used only under `ZAP_BUS_TIMEOUT_EN`.
- `i_clk` in 1: clock.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `i_clear_from_writeback` in 1: pipeline flush; kills the pending instruction response.
- `i_instr_req` in 1: fetch request, level, held until `o_instr_done`.
- `i_instr_addr` in 32: fetch address, word aligned.
- `i_data_req` in 1: data request, level, held until `o_data_done`.
- `i_data_we` in 1: 1 = store.
- `i_data_addr` in 32: byte address.
- `i_data_size` in 2: 0 byte, 1 half, 2 word.
- `i_data_wdata` in 32: store data, right-aligned.
- `o_instr_stall` out 1: `i_instr_req & ~o_instr_done`.
- `o_instr_done` out 1: one-cycle response pulse.
- `o_instr_rdata` out 32: fetched word.
- `o_instr_abort` out 1: fetch bus error, valid with done.
- `o_data_stall` out 1: `i_data_req & ~o_data_done`; drives memory-stage `i_data_stall`.
- `o_data_done` out 1: one-cycle response pulse.
- `o_data_rdata` out 32: raw read word.
- `o_data_fault` out 1: data bus error, valid with done.
- `o_bus_stb` out 1: cycle strobe.
- `o_bus_we` out 1: write enable.
- `o_bus_addr` out 32: `{addr[31:2],2'b00}`.
- `o_bus_sel` out 4: byte-lane enables.
- `o_bus_wdata` out 32: lane-replicated store data.
- `i_bus_ack` in 1: transfer complete.
- `i_bus_err` in 1: transfer error.
- `i_bus_rdata` in 32: read data, valid with ack.

## Operation
- FSM states: IDLE, DATA, INSTR, RESP.
- IDLE: samples requests and loads the bus registers.
  - Data only -> DATA. Instr only -> INSTR.
  - Both -> DATA, unless the last grant was DATA; then INSTR (alternating fairness).
- DATA/INSTR: strobe and all bus outputs hold stable until `i_bus_ack` or `i_bus_err`. Then strobe drops, read data and error are captured, and the FSM goes to RESP.
- RESP: the matching done pulse is high for one cycle; no new request is sampled; the FSM goes to IDLE.
- Byte select: byte -> `4'b0001 << addr[1:0]`, wdata = byte×4. Half -> `addr[1] ? 4'b1100 : 4'b0011`, wdata = half×2. Word -> `4'hF`.
- Size 3: treated as word.
- Reads use the same select.
- `i_bus_err` takes precedence over `i_bus_ack` when both are high.
- `i_clear_from_writeback` during INSTR or RESP (instruction): the bus cycle still completes, but `o_instr_done` and `o_instr_abort` are suppressed.
- Data accesses are never killed by clear.
- Requester dropping req mid-access: the access completes and the done pulse is still issued.

## Timing
- Reset: all outputs 0, FSM IDLE, last-grant = INSTR.
- Combinational stall outputs evaluate 0 only because their requests are 0.
- Request seen in IDLE at cycle 0. `o_bus_stb` is high from cycle 1.
- Ack at cycle n (n ≥ 1): `o_bus_stb` is low at n+1 with done high at n+1, and the FSM returns to IDLE at n+2.
- Minimum access time: 3 cycles.
- Back-to-back requests incur one IDLE cycle between accesses.
- All outputs are registered except the two stalls.

## Configuration
- `ZAP_BUS_TIMEOUT_EN` defined: a counter clears on entering DATA/INSTR. If it reaches `TIMEOUT_CYCLES` without ack/err, the access ends as if `i_bus_err` had been asserted: strobe drops, fault/abort is set, RESP follows.
- Undefined: no counter; an access waits indefinitely for ack/err.

## Structure
- Shared package `zap_mem_bus_pkg`:
  - FSM state encoding.
  - Size encodings (BYTE=0, HALF=1, WORD=2).
  - Default timeout constant.
- One sub-module, `zap_mem_sel_gen`: combinational size/address to `sel` and replicated `wdata`.

## Test plan
- Data read, size word, addr 0x1000, ack one cycle after strobe -> `o_bus_sel=F`, `o_bus_addr=0x1000`; `o_data_done` at cycle 2 with `o_data_rdata=i_bus_rdata`; `o_data_stall` high for cycles 0–1.
- Byte store 0xAB at addr 0x2003 -> `sel=1000`, `wdata=0xABABABAB`. Half store 0x1234 at 0x2002 -> `sel=1100`, `wdata=0x12341234`.
- Both requests held continuously -> grants alternate DATA, INSTR, DATA, INSTR; the first grant after reset is DATA.
- Instr access with `i_clear_from_writeback` pulsed mid-access -> strobe held until ack; `o_instr_done` never pulses; the next request proceeds normally.
- `i_bus_err` with ack on a data read -> `o_data_fault=1` with done. With `ZAP_BUS_TIMEOUT_EN` and `TIMEOUT_CYCLES=4`, no ack -> strobe drops after 4 cycles and the fault is flagged.
- Reset asserted mid-DATA -> strobe low asynchronously, FSM IDLE, all outputs 0.
